// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : cpu_pipe_pkg                                              |
// | Purpose  : Shared pipeline-control encodings for the 5-stage core.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package cpu_pipe_pkg;

   // Operand source select for the EX-stage ALU inputs
   typedef enum logic [1:0] {
      FWD_REGFILE = 2'b00,
      FWD_WB      = 2'b01,
      FWD_MEM     = 2'b10
   } fwd_sel_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Opcodes whose resolution in MEM may redirect the fetch stream
   function automatic logic is_redirect_opc(input logic [6:0] opc);
      return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hazard_fwd_sel                                            |
// | Purpose  : EX-stage operand forwarding selects (EX_MEM beats MEM_WB).|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module hazard_fwd_sel
   import cpu_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs1_ex,
   input  logic [REG_ADDR_W-1:0] rs2_ex,
   input  logic [REG_ADDR_W-1:0] rd_mem,
   input  logic                  reg_write_mem,
   input  logic [REG_ADDR_W-1:0] rd_wb,
   input  logic                  reg_write_wb,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b
);

   logic [1:0][REG_ADDR_W-1:0] w_rs;
   logic [1:0][1:0]            w_fwd;

   assign w_rs[0] = rs1_ex;
   assign w_rs[1] = rs2_ex;

   for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      // x0 is hard-wired zero and must never be forwarded
      always_comb begin
         w_fwd[gi] = FWD_REGFILE;
         if (w_rs[gi] != '0) begin
            if (reg_write_mem && (rd_mem == w_rs[gi])) begin
               w_fwd[gi] = FWD_MEM;
            end else if (reg_write_wb && (rd_wb == w_rs[gi])) begin
               w_fwd[gi] = FWD_WB;
            end
         end
      end
   end

   assign forward_a = w_fwd[0];
   assign forward_b = w_fwd[1];

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipeline_hazard_ctrl                                      |
// | Purpose  : Stage enables/flushes, stalls, forwarding and perf counts.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pipeline_hazard_ctrl
   import cpu_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int MUL_LAT    = 3,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  enable,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  uses_rs2_id,
   input  logic [REG_ADDR_W-1:0] rs1_ex,
   input  logic [REG_ADDR_W-1:0] rs2_ex,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic                  mem_read_ex,
   input  logic                  is_mul_ex,
   input  logic [REG_ADDR_W-1:0] rd_mem,
   input  logic                  reg_write_mem,
   input  logic [REG_ADDR_W-1:0] rd_wb,
   input  logic                  reg_write_wb,
   input  logic                  redirect_mem,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  ex_mem_en,
   output logic                  mem_wb_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b,
   output logic                  mul_busy,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);

   localparam int                 c_MUL_W   = $clog2(MUL_LAT) + 1;
   localparam logic [c_MUL_W-1:0] c_MUL_LIM = c_MUL_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0]   c_CNT_MAX = {CNT_W{1'b1}};

   logic               r_run;
   logic [c_MUL_W-1:0] r_mul_cnt;
   logic [CNT_W-1:0]   r_stall_cycles;
   logic [CNT_W-1:0]   r_flush_count;

   logic w_load_use_raw;
   logic w_mul_stall;
   logic w_load_use;

   assign w_load_use_raw = mem_read_ex && (rd_ex != '0) &&
                           ((rd_ex == rs1_id) || (uses_rs2_id && (rd_ex == rs2_id)));

   // Redirect outranks the multiply stall, which in turn hides load-use
   assign w_mul_stall = r_run && !redirect_mem && is_mul_ex && (r_mul_cnt < c_MUL_LIM);
   assign w_load_use  = r_run && !redirect_mem && !w_mul_stall && w_load_use_raw;

   always_comb begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      if (r_run) begin
         pc_en     = 1'b1;
         if_id_en  = 1'b1;
         id_ex_en  = 1'b1;
         ex_mem_en = 1'b1;
         mem_wb_en = 1'b1;
         if (redirect_mem) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
         end else if (w_mul_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
         end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end
      end
   end

   assign mul_busy = w_mul_stall;

   // While run is low all state freezes so execution resumes where it left off
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_run          <= 1'b0;
         r_mul_cnt      <= '0;
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         r_run <= enable;
         if (r_run) begin
            if (w_mul_stall) begin
               r_mul_cnt <= r_mul_cnt + c_MUL_W'(1);
            end else begin
               r_mul_cnt <= '0;
            end
            if (redirect_mem && (r_flush_count != c_CNT_MAX)) begin
               r_flush_count <= r_flush_count + CNT_W'(1);
            end
            if (!pc_en && (r_stall_cycles != c_CNT_MAX)) begin
               r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;

   hazard_fwd_sel #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_sel (
      .rs1_ex        (rs1_ex),
      .rs2_ex        (rs2_ex),
      .rd_mem        (rd_mem),
      .reg_write_mem (reg_write_mem),
      .rd_wb         (rd_wb),
      .reg_write_wb  (reg_write_wb),
      .forward_a     (forward_a),
      .forward_b     (forward_b)
   );

endmodule
`default_nettype wire
